serial_addsub_engine: RTL and testbench

Parametrised, digit-serial add/subtract engine that extends the team's bit-serial adder to full-word operands. It processes D bits per clock, LSB-first, with add or subtract mode and a start/busy/done handshake. It produces both a per-cycle digit stream and a registered full-width result with carry and signed-overflow flags. It sits between a register-file read port and a narrow datapath wherever area matters more than latency.

---
 rtl/serial_addsub_engine.sv | 96 +++++++++
 tb/tb_serial_addsub_engine.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_engine.sv
// Digit-serial add/subtract engine: D bits per clock, LSB-first, with a
// per-cycle digit stream and a registered full-width result plus carry/overflow.
module serial_addsub_engine #(
  parameter int unsigned W = 16,
  parameter int unsigned D = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [D-1:0] sout,
  output logic         sout_valid,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);
  localparam int unsigned N  = W / D;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        r_state;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_res;
  logic          r_c;
  logic [KW-1:0] r_k;

  logic [D:0]    w_digit;
  logic          w_msb_cin;
  logic [W-1:0]  w_res_next;

  always_comb begin
    w_digit    = {1'b0, r_a[D-1:0]} + {1'b0, r_b[D-1:0]} + {{D{1'b0}}, r_c};
    // Carry into the top bit of the digit, recovered from its sum bit; for D=1 this is r_c.
    w_msb_cin  = w_digit[D-1] ^ r_a[D-1] ^ r_b[D-1];
    // New digit enters at the top; written as a wide shift so D == W needs no special case.
    w_res_next = W'({w_digit[D-1:0], r_res} >> D);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_res      <= '0;
      r_c        <= 1'b0;
      r_k        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sout       <= '0;
      sout_valid <= 1'b0;
      sum        <= '0;
      cout       <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      done       <= 1'b0;
      sout_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_c     <= cin ^ sub;
            r_k     <= '0;
            busy    <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          sout       <= w_digit[D-1:0];
          sout_valid <= 1'b1;
          r_c        <= w_digit[D];
          r_a        <= r_a >> D;
          r_b        <= r_b >> D;
          r_res      <= w_res_next;
          r_k        <= r_k + KW'(1);
          if (r_k == K_LAST) begin
            sum     <= w_res_next;
            cout    <= w_digit[D];
            ovf     <= w_msb_cin ^ w_digit[D];
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_addsub_engine.sv
// Self-checking bench: directed W=8 cases plus a randomized W=16 regression
// over all digit widths against an integer-arithmetic reference model.
module tb_serial_addsub_engine;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // W=8, D=1
  logic       p_start, p_sub, p_cin;
  logic [7:0] p_a, p_b;
  logic       p_busy, p_done, p_sv, p_cout, p_ovf;
  logic [0:0] p_sout;
  logic [7:0] p_sum;

  serial_addsub_engine #(.W(8), .D(1)) u_p (
    .clk(clk), .reset(reset), .start(p_start), .sub(p_sub), .a(p_a), .b(p_b),
    .cin(p_cin), .busy(p_busy), .done(p_done), .sout(p_sout), .sout_valid(p_sv),
    .sum(p_sum), .cout(p_cout), .ovf(p_ovf)
  );

  // W=8, D=4
  logic       q_start, q_sub, q_cin;
  logic [7:0] q_a, q_b;
  logic       q_busy, q_done, q_sv, q_cout, q_ovf;
  logic [3:0] q_sout;
  logic [7:0] q_sum;

  serial_addsub_engine #(.W(8), .D(4)) u_q (
    .clk(clk), .reset(reset), .start(q_start), .sub(q_sub), .a(q_a), .b(q_b),
    .cin(q_cin), .busy(q_busy), .done(q_done), .sout(q_sout), .sout_valid(q_sv),
    .sum(q_sum), .cout(q_cout), .ovf(q_ovf)
  );

  // W=16, D = 1,2,4,8,16
  logic        g_start;
  logic        g_sub, g_cin;
  logic [15:0] g_a, g_b;
  logic [4:0]  g_busy, g_done, g_sv, g_cout, g_ovf;
  logic [15:0] g_sout [5];
  logic [15:0] g_sum  [5];

  for (genvar gi = 0; gi < 5; gi++) begin : g16
    localparam int unsigned DG = 1 << gi;
    logic [DG-1:0] w_sout;
    serial_addsub_engine #(.W(16), .D(DG)) u_dut (
      .clk(clk), .reset(reset), .start(g_start), .sub(g_sub), .a(g_a), .b(g_b),
      .cin(g_cin), .busy(g_busy[gi]), .done(g_done[gi]), .sout(w_sout),
      .sout_valid(g_sv[gi]), .sum(g_sum[gi]), .cout(g_cout[gi]), .ovf(g_ovf[gi])
    );
    assign g_sout[gi] = 16'(w_sout);
  end

  // Reference: exact integer arithmetic, unsigned for sum/carry, signed for overflow.
  function automatic void ref_model(input int w, input logic [15:0] a, input logic [15:0] b,
                                    input logic sub, input logic cin,
                                    output logic [15:0] s, output logic co, output logic ov);
    longint m, ua, ub, ci, t, sa, sb, st;
    m  = longint'(1) << w;
    ua = a;
    ub = b;
    ci = cin ? 1 : 0;
    if (!sub) begin
      t  = ua + ub + ci;
      co = (t >= m);
    end else begin
      t  = ua - ub - ci;
      co = (t >= 0);
    end
    s  = 16'(t & (m - 1));
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    st = sub ? (sa - sb - ci) : (sa + sb + ci);
    ov = (st < -(m / 2)) || (st >= m / 2);
  endfunction

  // Stimulus helpers (no checking). Called at a negedge; return at the done negedge.
  task automatic run_p(input logic [7:0] a, input logic [7:0] b, input logic sub, input logic cin,
                       output int lat, output int nd, output logic [7:0] stream);
    p_a = a; p_b = b; p_sub = sub; p_cin = cin; p_start = 1'b1;
    @(negedge clk);
    p_start = 1'b0;
    lat = -1; nd = 0; stream = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (p_sv) begin
        if (nd < 8) stream[nd] = p_sout[0];
        nd++;
      end
      if (p_done) begin lat = c; break; end
    end
  endtask

  task automatic run_q(input logic [7:0] a, input logic [7:0] b, input logic sub, input logic cin,
                       output int lat, output int nd, output logic [7:0] stream);
    q_a = a; q_b = b; q_sub = sub; q_cin = cin; q_start = 1'b1;
    @(negedge clk);
    q_start = 1'b0;
    lat = -1; nd = 0; stream = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (q_sv) begin
        if (nd < 2) stream[nd*4 +: 4] = q_sout;
        nd++;
      end
      if (q_done) begin lat = c; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if ({p_busy, p_done, p_sv, p_sout, p_cout, p_ovf} !== 6'b0) begin
      n_err++; $display("FAIL reset_flags: got %b expected 000000", {p_busy, p_done, p_sv, p_sout, p_cout, p_ovf});
    end
    n_cmp++; if (p_sum !== 8'h00) begin n_err++; $display("FAIL reset_sum: got %h expected 00", p_sum); end
    n_cmp++; if ({g_busy, g_done, g_sv} !== 15'b0) begin
      n_err++; $display("FAIL reset_g16: got %b expected 0", {g_busy, g_done, g_sv});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add_overflow();
    int lat, nd; logic [7:0] st;
    run_p(8'h7F, 8'h01, 1'b0, 1'b0, lat, nd, st);
    n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL add_lat: got %0d expected 8", lat); end
    n_cmp++; if (nd !== 8) begin n_err++; $display("FAIL add_ndig: got %0d expected 8", nd); end
    n_cmp++; if (st !== 8'h80) begin n_err++; $display("FAIL add_stream: got %h expected 80", st); end
    n_cmp++; if (p_sum !== 8'h80) begin n_err++; $display("FAIL add_sum: got %h expected 80", p_sum); end
    n_cmp++; if ({p_cout, p_ovf} !== 2'b01) begin n_err++; $display("FAIL add_flags: got %b expected 01", {p_cout, p_ovf}); end
    n_cmp++; if (p_busy !== 1'b0) begin n_err++; $display("FAIL add_busy_at_done: got %b expected 0", p_busy); end
  endtask

  task automatic test_sub();
    int lat, nd; logic [7:0] st;
    run_p(8'h05, 8'h07, 1'b1, 1'b0, lat, nd, st);
    n_cmp++; if (p_sum !== 8'hFE) begin n_err++; $display("FAIL sub1_sum: got %h expected fe", p_sum); end
    n_cmp++; if ({p_cout, p_ovf} !== 2'b00) begin n_err++; $display("FAIL sub1_flags: got %b expected 00", {p_cout, p_ovf}); end
    n_cmp++; if (st !== 8'hFE) begin n_err++; $display("FAIL sub1_stream: got %h expected fe", st); end
    run_p(8'h80, 8'h01, 1'b1, 1'b0, lat, nd, st);
    n_cmp++; if (p_sum !== 8'h7F) begin n_err++; $display("FAIL sub2_sum: got %h expected 7f", p_sum); end
    n_cmp++; if ({p_cout, p_ovf} !== 2'b11) begin n_err++; $display("FAIL sub2_flags: got %b expected 11", {p_cout, p_ovf}); end
  endtask

  task automatic test_digit4();
    int lat, nd; logic [7:0] st;
    run_q(8'hFF, 8'h01, 1'b0, 1'b1, lat, nd, st);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL d4_lat: got %0d expected 2", lat); end
    n_cmp++; if (nd !== 2) begin n_err++; $display("FAIL d4_ndig: got %0d expected 2", nd); end
    n_cmp++; if (st !== 8'h01) begin n_err++; $display("FAIL d4_stream: got %h expected 01", st); end
    n_cmp++; if (q_sum !== 8'h01) begin n_err++; $display("FAIL d4_sum: got %h expected 01", q_sum); end
    n_cmp++; if ({q_cout, q_ovf} !== 2'b10) begin n_err++; $display("FAIL d4_flags: got %b expected 10", {q_cout, q_ovf}); end
  endtask

  task automatic test_back_to_back();
    int lat, nd; logic [7:0] st;
    p_a = 8'h12; p_b = 8'h34; p_sub = 1'b0; p_cin = 1'b0; p_start = 1'b1;
    @(negedge clk);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      if (c == 3) begin
        p_start = 1'b1; p_a = 8'hAA; p_b = 8'hCC; p_sub = 1'b1; p_cin = 1'b1;
      end else begin
        p_start = 1'b0;
      end
      @(negedge clk);
      if (p_done) begin lat = c; break; end
    end
    n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL ign_lat: got %0d expected 8", lat); end
    n_cmp++; if (p_sum !== 8'h46) begin n_err++; $display("FAIL ign_sum: got %h expected 46", p_sum); end
    n_cmp++; if ({p_cout, p_ovf} !== 2'b00) begin n_err++; $display("FAIL ign_flags: got %b expected 00", {p_cout, p_ovf}); end
    run_p(8'h90, 8'h10, 1'b1, 1'b0, lat, nd, st);
    n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL b2b_lat: got %0d expected 8", lat); end
    n_cmp++; if (p_sum !== 8'h80) begin n_err++; $display("FAIL b2b_sum: got %h expected 80", p_sum); end
    n_cmp++; if ({p_cout, p_ovf} !== 2'b10) begin n_err++; $display("FAIL b2b_flags: got %b expected 10", {p_cout, p_ovf}); end
  endtask

  task automatic test_reset_abort();
    int lat, nd; logic [7:0] st; bit seen;
    p_a = 8'h0F; p_b = 8'h01; p_sub = 1'b0; p_cin = 1'b0; p_start = 1'b1;
    @(negedge clk);
    p_start = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++; if ({p_busy, p_done, p_sv, p_sout, p_cout, p_ovf} !== 6'b0) begin
      n_err++; $display("FAIL abort_flags: got %b expected 000000", {p_busy, p_done, p_sv, p_sout, p_cout, p_ovf});
    end
    n_cmp++; if (p_sum !== 8'h00) begin n_err++; $display("FAIL abort_sum: got %h expected 00", p_sum); end
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (p_done) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL abort_no_done: got %b expected 0", seen); end
    run_p(8'h3C, 8'h0A, 1'b0, 1'b1, lat, nd, st);
    n_cmp++; if (p_sum !== 8'h47) begin n_err++; $display("FAIL abort_next_sum: got %h expected 47", p_sum); end
    n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL abort_next_lat: got %0d expected 8", lat); end
  endtask

  task automatic test_random();
    logic [15:0] ta, tb_v, es;
    logic ts, tc, ec, eo;
    logic [15:0] st [5];
    logic [15:0] ev [5];
    int nd [5];
    int lat [5];
    int dg;
    bit alld;
    ev = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
    for (int op = 0; op < 1000; op++) begin
      if (op % 8 == 0) begin
        ta = ev[$urandom_range(4)]; tb_v = ev[$urandom_range(4)];
      end else begin
        ta = 16'($urandom); tb_v = 16'($urandom);
      end
      ts = 1'($urandom); tc = 1'($urandom);
      g_a = ta; g_b = tb_v; g_sub = ts; g_cin = tc; g_start = 1'b1;
      for (int i = 0; i < 5; i++) begin st[i] = '0; nd[i] = 0; lat[i] = -1; end
      @(negedge clk);
      g_start = 1'b0;
      g_a = 16'($urandom); g_b = 16'($urandom); g_sub = 1'($urandom); g_cin = 1'($urandom);
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        alld = 1'b1;
        for (int i = 0; i < 5; i++) begin
          dg = 1 << i;
          if (g_sv[i]) begin
            st[i] = st[i] | (g_sout[i] << (nd[i] * dg));
            nd[i]++;
          end
          if (g_done[i] && lat[i] < 0) lat[i] = c;
          if (lat[i] < 0) alld = 1'b0;
        end
        if (alld) break;
      end
      ref_model(16, ta, tb_v, ts, tc, es, ec, eo);
      for (int i = 0; i < 5; i++) begin
        dg = 1 << i;
        n_cmp++; if (lat[i] !== 16 / dg) begin n_err++; $display("FAIL rnd_lat D=%0d op=%0d: got %0d expected %0d", dg, op, lat[i], 16 / dg); end
        n_cmp++; if (g_sum[i] !== es) begin n_err++; $display("FAIL rnd_sum D=%0d op=%0d: got %h expected %h", dg, op, g_sum[i], es); end
        n_cmp++; if ({g_cout[i], g_ovf[i]} !== {ec, eo}) begin n_err++; $display("FAIL rnd_flags D=%0d op=%0d: got %b expected %b", dg, op, {g_cout[i], g_ovf[i]}, {ec, eo}); end
        n_cmp++; if (st[i] !== es || nd[i] !== 16 / dg) begin n_err++; $display("FAIL rnd_stream D=%0d op=%0d: got %h/%0d digits expected %h/%0d", dg, op, st[i], nd[i], es, 16 / dg); end
      end
    end
  endtask

  initial begin
    p_start = 1'b0; p_sub = 1'b0; p_cin = 1'b0; p_a = '0; p_b = '0;
    q_start = 1'b0; q_sub = 1'b0; q_cin = 1'b0; q_a = '0; q_b = '0;
    g_start = 1'b0; g_sub = 1'b0; g_cin = 1'b0; g_a = '0; g_b = '0;
    test_reset();
    test_add_overflow();
    test_sub();
    test_digit4();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
